// File: rtl/jtdd_shram_pkg.sv
// Shared types for the host/MCU shared-RAM arbiter: grant FSM states, owner codes
// and the per-side access phase tracker.
package jtdd_shram_pkg;

  typedef enum logic [1:0] {IDLE, GNT_H, GNT_M} state_t;

  // PH_RDAT: access done, read data lands in dout on the next cen
  // PH_DONE: wait is low for this requester until the next cen
  typedef enum logic [1:0] {PH_IDLE, PH_RDAT, PH_DONE} phase_t;

  localparam logic OWN_H = 1'b1;
  localparam logic OWN_M = 1'b0;

  function automatic phase_t ph_next(phase_t ph, logic gnt, logic we);
    if (gnt) return we ? PH_DONE : PH_RDAT;
    return (ph == PH_RDAT) ? PH_DONE : PH_IDLE;
  endfunction

endpackage

// File: rtl/jtdd_shram_arb_if.sv
// Host and MCU request buses into the shared-RAM arbiter.
// master = bus decoder / MCU side, slave = arbiter.
interface jtdd_shram_arb_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  logic          host_cs;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_din;
  logic [DW-1:0] host_dout;
  logic          host_wait;
  logic          mcu_cs;
  logic          mcu_we;
  logic [AW-1:0] mcu_addr;
  logic [DW-1:0] mcu_din;
  logic [DW-1:0] mcu_dout;
  logic          mcu_wait;

  modport master (
    output host_cs, host_we, host_addr, host_din,
    output mcu_cs, mcu_we, mcu_addr, mcu_din,
    input  host_dout, host_wait, mcu_dout, mcu_wait
  );

  modport slave (
    input  host_cs, host_we, host_addr, host_din,
    input  mcu_cs, mcu_we, mcu_addr, mcu_din,
    output host_dout, host_wait, mcu_dout, mcu_wait
  );
endinterface

// File: rtl/jtdd_doorbell.sv
// One doorbell channel: rising edge on set raises irq, clr level drops it.
// Latency one clk from edge to irq; an edge beats a simultaneous clr.
module jtdd_doorbell (
  input  logic clk,
  input  logic rstn,
  input  logic set,
  input  logic clr,
  output logic irq
);
  logic set_l;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      set_l <= 1'b0;
      irq   <= 1'b0;
    end else begin
      set_l <= set;
      if (set && !set_l) irq <= 1'b1;
      else if (clr)      irq <= 1'b0;
    end
  end
endmodule

// File: rtl/jtframe_ram.sv
// Single-port synchronous RAM, read-before-write, one cycle read latency.
// Accesses only happen on cen; contents are never reset.
module jtframe_ram #(
  parameter int dw = 8,
  parameter int aw = 9
)(
  input  logic          clk,
  input  logic          cen,
  input  logic [dw-1:0] data,
  input  logic [aw-1:0] addr,
  input  logic          we,
  output logic [dw-1:0] q
);
  logic [dw-1:0] mem [2**aw];

  always_ff @(posedge clk) begin
    if (cen) begin
      q <= mem[addr];
      if (we) mem[addr] <= data;
    end
  end
endmodule

// File: rtl/jtdd_shram_arb.sv
// Round-robin host/MCU shared-RAM arbiter with MCU halt override and doorbells.
// Write completes one cen after grant, read one cen later; stalls via x_wait.
module jtdd_shram_arb
  import jtdd_shram_pkg::*;
#(
  parameter int AW         = 9,
  parameter int DW         = 8,
  parameter int MBOX_N     = 2,
  parameter bit HOST_FIRST = 1'b0
)(
  input  logic              clk,
  input  logic              rstn,
  input  logic              cen,
  jtdd_shram_arb_if.slave   bus,
  input  logic              mcu_haltn,
  input  logic [MBOX_N-1:0] door_set,
  input  logic [MBOX_N-1:0] door_clr,
  output logic [MBOX_N-1:0] door_irq
);
  state_t        state, nxt;
  phase_t        ph_h, ph_m;
  logic          last_owner;
  logic          req_h, req_m;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_q;

  // A side being served, or waiting for its read data, is not a new request.
  always_comb begin
    req_h = bus.host_cs && (ph_h != PH_RDAT) && (state != GNT_H);
    req_m = bus.mcu_cs && mcu_haltn && (ph_m != PH_RDAT) && (state != GNT_M);
    nxt   = IDLE;
    if (req_h && req_m) nxt = (last_owner == OWN_H) ? GNT_M : GNT_H;
    else if (req_h)     nxt = GNT_H;
    else if (req_m)     nxt = GNT_M;
  end

  assign ram_addr = (state == GNT_M) ? bus.mcu_addr : bus.host_addr;
  assign ram_din  = (state == GNT_M) ? bus.mcu_din  : bus.host_din;
  assign ram_we   = ((state == GNT_H) && bus.host_cs && bus.host_we) ||
                    ((state == GNT_M) && bus.mcu_cs  && bus.mcu_we);

  assign bus.host_wait = bus.host_cs && (ph_h != PH_DONE);
  assign bus.mcu_wait  = bus.mcu_cs  && (ph_m != PH_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      last_owner   <= ~HOST_FIRST;
      ph_h         <= PH_IDLE;
      ph_m         <= PH_IDLE;
      bus.host_dout <= '0;
      bus.mcu_dout  <= '0;
    end else if (cen) begin
      state <= nxt;
      if (state == GNT_H)      last_owner <= OWN_H;
      else if (state == GNT_M) last_owner <= OWN_M;
      ph_h <= ph_next(ph_h, state == GNT_H, bus.host_we);
      ph_m <= ph_next(ph_m, state == GNT_M, bus.mcu_we);
      if (ph_h == PH_RDAT) bus.host_dout <= ram_q;
      if (ph_m == PH_RDAT) bus.mcu_dout  <= ram_q;
    end
  end

  jtframe_ram #(.dw(DW), .aw(AW)) u_ram (
    .clk  (clk),
    .cen  (cen),
    .data (ram_din),
    .addr (ram_addr),
    .we   (ram_we),
    .q    (ram_q)
  );

  for (genvar i = 0; i < MBOX_N; i++) begin : g_door
    jtdd_doorbell u_door (
      .clk  (clk),
      .rstn (rstn),
      .set  (door_set[i]),
      .clr  (door_clr[i]),
      .irq  (door_irq[i])
    );
  end
endmodule

// File: tb/tb_jtdd_shram_arb.sv
// Directed bench for jtdd_shram_arb: inputs change on the falling edge,
// outputs are sampled on the falling edge after each rising edge.
module tb_jtdd_shram_arb;
  import jtdd_shram_pkg::*;

  logic       clk = 1'b0;
  logic       rstn, cen, mcu_haltn;
  logic [1:0] door_set, door_clr, door_irq;
  int         checks = 0;
  int         failures = 0;
  int         cen_mode = 0;   // 0: always on, 1: one in three, 2: off
  int         cen_ph = 0;

  jtdd_shram_arb_if #(.AW(9), .DW(8)) bus ();

  jtdd_shram_arb #(.AW(9), .DW(8), .MBOX_N(2), .HOST_FIRST(1'b0)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cen       (cen),
    .bus       (bus),
    .mcu_haltn (mcu_haltn),
    .door_set  (door_set),
    .door_clr  (door_clr),
    .door_irq  (door_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    case (cen_mode)
      0: cen = 1'b1;
      1: begin
        cen    = (cen_ph == 0);
        cen_ph = (cen_ph == 2) ? 0 : cen_ph + 1;
      end
      default: cen = 1'b0;
    endcase
  endtask

  // Step to a falling edge whose following rising edge carries cen.
  task automatic align();
    cyc();
    for (int i = 0; i < 3 && cen_mode == 1 && !cen; i++) cyc();
  endtask

  // One access; nw counts samples with wait high (40 means it never finished).
  task automatic acc(input bit mside, input logic we, input logic [8:0] a,
                     input logic [7:0] d, output int nw);
    align();
    if (mside) begin
      bus.mcu_cs = 1'b1; bus.mcu_we = we; bus.mcu_addr = a; bus.mcu_din = d;
    end else begin
      bus.host_cs = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_din = d;
    end
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (!(mside ? bus.mcu_wait : bus.host_wait)) break;
      nw++;
    end
    if (mside) begin
      bus.mcu_cs = 1'b0; bus.mcu_we = 1'b0;
    end else begin
      bus.host_cs = 1'b0; bus.host_we = 1'b0;
    end
  endtask

  initial begin
    int         nw, hc, mc, cnt;
    logic [3:0] ord;

    rstn = 1'b0; cen = 1'b1; mcu_haltn = 1'b1; door_set = '0; door_clr = '0;
    bus.host_cs = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_din = '0;
    bus.mcu_cs  = 1'b0; bus.mcu_we  = 1'b0; bus.mcu_addr  = '0; bus.mcu_din  = '0;
    repeat (3) @(negedge clk);
    chk("rst_host_dout", bus.host_dout, 8'h00);
    chk("rst_mcu_dout", bus.mcu_dout, 8'h00);
    chk("rst_irq", door_irq, 2'b00);
    chk("rst_host_wait", bus.host_wait, 1'b0);
    chk("rst_mcu_wait", bus.mcu_wait, 1'b0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rstn = 1'b1;

    // Single host write then read of the top word
    acc(1'b0, 1'b1, 9'h1FF, 8'hA5, nw);
    chk("h_wr_wait", nw, 1);
    acc(1'b0, 1'b0, 9'h1FF, 8'h00, nw);
    chk("h_rd_wait", nw, 2);
    chk("h_rd_dat", bus.host_dout, 8'hA5);

    // Contention: both held, two writes each, expect M,H,M,H
    align();
    bus.host_cs = 1'b1; bus.host_we = 1'b1; bus.host_addr = 9'h020; bus.host_din = 8'h11;
    bus.mcu_cs  = 1'b1; bus.mcu_we  = 1'b1; bus.mcu_addr  = 9'h030; bus.mcu_din  = 8'h22;
    hc = 0; mc = 0; ord = '0;
    for (int i = 0; i < 20 && (hc + mc) < 4; i++) begin
      cyc();
      if (bus.mcu_cs && !bus.mcu_wait) begin
        ord = {ord[2:0], 1'b0}; mc++;
        if (mc == 2) begin bus.mcu_cs = 1'b0; bus.mcu_we = 1'b0; end
      end
      if (bus.host_cs && !bus.host_wait) begin
        ord = {ord[2:0], 1'b1}; hc++;
        if (hc == 2) begin bus.host_cs = 1'b0; bus.host_we = 1'b0; end
      end
    end
    bus.host_cs = 1'b0; bus.host_we = 1'b0; bus.mcu_cs = 1'b0; bus.mcu_we = 1'b0;
    chk("rr_order", ord, 4'b0101);
    chk("rr_host_cnt", hc, 2);
    chk("rr_mcu_cnt", mc, 2);
    acc(1'b0, 1'b0, 9'h030, 8'h00, nw);
    chk("rr_h_reads_m", bus.host_dout, 8'h22);
    acc(1'b1, 1'b0, 9'h020, 8'h00, nw);
    chk("rr_m_rd_wait", nw, 2);
    chk("rr_m_reads_h", bus.mcu_dout, 8'h11);

    // Halt arriving during an MCU write
    align();
    bus.mcu_cs = 1'b1; bus.mcu_we = 1'b1; bus.mcu_addr = 9'h010; bus.mcu_din = 8'h3C;
    cyc();
    chk("halt_wr_busy", bus.mcu_wait, 1'b1);
    mcu_haltn = 1'b0;
    cyc();
    chk("halt_wr_done", bus.mcu_wait, 1'b0);
    bus.mcu_cs = 1'b0; bus.mcu_we = 1'b0;
    cyc();
    bus.mcu_cs = 1'b1; bus.mcu_addr = 9'h010;
    acc(1'b0, 1'b0, 9'h010, 8'h00, nw);
    chk("halt_h_rd_wait", nw, 2);
    chk("halt_h_rd_dat", bus.host_dout, 8'h3C);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (bus.mcu_wait) cnt++;
    end
    chk("halt_m_stall", cnt, 3);
    mcu_haltn = 1'b1;
    nw = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (!bus.mcu_wait) break;
      nw++;
    end
    chk("halt_rel_wait", nw, 2);
    chk("halt_m_rd_dat", bus.mcu_dout, 8'h3C);
    bus.mcu_cs = 1'b0;

    // Doorbells
    cyc();
    door_set[1] = 1'b1; door_clr[1] = 1'b1;
    cyc();
    chk("door_set_beats_clr", door_irq, 2'b10);
    door_set = '0; door_clr = '0;
    cyc();
    chk("door_hold", door_irq, 2'b10);
    door_clr[1] = 1'b1;
    cyc();
    chk("door_clr", door_irq, 2'b00);
    door_clr[1] = 1'b0;
    door_set[1] = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (door_irq[1]) cnt++;
      door_clr[1] = (i == 2);
    end
    chk("door_level_once", cnt, 2);
    chk("door_ch0_idle", door_irq[0], 1'b0);
    door_set = '0; door_clr = '0;

    // Reset during an MCU grant with a pending doorbell
    align();
    door_set[0] = 1'b1;
    bus.mcu_cs = 1'b1; bus.mcu_we = 1'b0; bus.mcu_addr = 9'h010;
    cyc();
    chk("arst_pre_state", 32'(dut.state), 32'(GNT_M));
    chk("arst_pre_irq", door_irq, 2'b01);
    #2 rstn = 1'b0;
    #1;
    chk("arst_irq", door_irq, 2'b00);
    chk("arst_host_dout", bus.host_dout, 8'h00);
    chk("arst_mcu_dout", bus.mcu_dout, 8'h00);
    chk("arst_state", 32'(dut.state), 32'(IDLE));
    bus.mcu_cs = 1'b0; door_set = '0;
    cyc();
    rstn = 1'b1;
    align();
    bus.host_cs = 1'b1; bus.host_we = 1'b1; bus.host_addr = 9'h040; bus.host_din = 8'h77;
    bus.mcu_cs  = 1'b1; bus.mcu_we  = 1'b1; bus.mcu_addr  = 9'h041; bus.mcu_din  = 8'h88;
    cyc();
    cyc();
    chk("arst_first_m", bus.mcu_wait, 1'b0);
    chk("arst_first_h_waits", bus.host_wait, 1'b1);
    bus.mcu_cs = 1'b0; bus.mcu_we = 1'b0;
    cyc();
    chk("arst_second_h", bus.host_wait, 1'b0);
    bus.host_cs = 1'b0; bus.host_we = 1'b0;

    // Clock enable one cycle in three, then fully off
    cen_mode = 1; cen_ph = 0;
    acc(1'b0, 1'b1, 9'h0AA, 8'h5A, nw);
    chk("cen_wr_wait", nw, 3);
    repeat (3) cyc();
    cen_mode = 2;
    cyc();
    bus.host_cs = 1'b1; bus.host_we = 1'b1; bus.host_addr = 9'h0AA; bus.host_din = 8'hFF;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (bus.host_wait) cnt++;
    end
    chk("cen_off_stall", cnt, 5);
    bus.host_cs = 1'b0; bus.host_we = 1'b0;
    cen_mode = 1;
    acc(1'b0, 1'b0, 9'h0AA, 8'h00, nw);
    chk("cen_rd_wait", nw, 6);
    chk("cen_rd_dat", bus.host_dout, 8'h5A);
    cen_mode = 0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
